// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel between fetch and memory.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO holding fetched instructions with their PCs.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Pointer and occupancy tracking; a flush empties the queue and beats any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Entry storage is only written by a push that is not cancelled by a flush.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers responses toward decode and handles redirect flushes.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    instr_fetch_unit_if.master  imem,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [ILEN-1:0]     if_instr,
    output logic [XLEN-1:0]     if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DROP = DROP;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign imem.imem_req_valid = (state == S_REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign imem.imem_req_addr  = fetch_pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    assign fifo_push        = (state == S_WAIT) && imem.imem_rsp_valid && !redirect_valid;
    assign fifo_pop         = if_valid && if_ready;
    assign push_entry.instr = imem.imem_rsp_data;
    assign push_entry.pc    = req_pc;

    assign if_valid = (fifo_count != '0);
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    // Next-state selection; a redirect turns any in-flight request into one whose response is dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (req_fire) state_next = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid)  state_next = S_REQ;
                else if (redirect_valid)  state_next = S_DROP;
            end
            S_DROP: begin
                if (imem.imem_rsp_valid)  state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, fetch PC and the PC of the outstanding request; redirect overrides the sequential increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + PC_STEP;
            if (req_fire)
                req_pc <= fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head       (head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected requests and decode-side
// entries are queued by the stimulus and checked by independent monitors.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst1;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        redirect_valid1;
    logic [63:0] redirect_pc1;
    logic        if_valid1;
    logic        if_ready1;
    logic [31:0] if_instr1;
    logic [63:0] if_pc1;

    int n_vectors = 0;
    int n_miscompares = 0;
    int mem_mode = 0;

    logic [63:0]  exp_req [$];
    fetch_entry_t exp_if  [$];

    instr_fetch_unit_if imem0 ();
    instr_fetch_unit_if imem1 ();

    instr_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem0),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk            (clk),
        .rst            (rst1),
        .redirect_valid (redirect_valid1),
        .redirect_pc    (redirect_pc1),
        .imem           (imem1),
        .if_valid       (if_valid1),
        .if_ready       (if_ready1),
        .if_instr       (if_instr1),
        .if_pc          (if_pc1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        if (mem_mode == 0) return 32'h0000_0013;
        return {addr[31:2], 2'b11};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mem_ready, input logic dec_ready);
        imem0.imem_req_ready = mem_ready;
        if_ready = dec_ready;
    endtask

    task automatic expect_entry(input logic [31:0] instr, input logic [63:0] pc);
        fetch_entry_t e;
        e.instr = instr;
        e.pc = pc;
        exp_if.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_fire(input logic [63:0] a);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (imem0.imem_req_valid && imem0.imem_req_ready && imem0.imem_req_addr == a)
                seen = 1'b1;
            else begin
                @(negedge clk);
                #2;
            end
        end
        if (!seen) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL fire_timeout: no request at %h, expected one within budget", a);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #3;
            done = (exp_if.size() == 0) && (exp_req.size() == 0);
        end
        if (!done) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL drain_timeout: pending req=%0d if=%0d, expected 0", exp_req.size(), exp_if.size());
        end
    endtask

    // Memory model for the main DUT: 1-cycle response to every accepted request.
    initial begin
        logic        pend;
        logic [63:0] pend_addr;
        pend = 1'b0;
        pend_addr = '0;
        imem0.imem_rsp_valid = 1'b0;
        imem0.imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                imem0.imem_rsp_valid = 1'b0;
                imem0.imem_rsp_data = '0;
                pend = 1'b0;
            end else begin
                imem0.imem_rsp_valid = pend;
                imem0.imem_rsp_data = pend ? mem_word(pend_addr) : 32'h0;
                pend = imem0.imem_req_valid && imem0.imem_req_ready;
                pend_addr = imem0.imem_req_addr;
            end
        end
    end

    // Memory model for the wrap-around DUT: always ready, constant instruction word.
    initial begin
        logic pend1;
        pend1 = 1'b0;
        imem1.imem_req_ready = 1'b1;
        imem1.imem_rsp_valid = 1'b0;
        imem1.imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst1) begin
                imem1.imem_rsp_valid = 1'b0;
                pend1 = 1'b0;
            end else begin
                imem1.imem_rsp_valid = pend1;
                imem1.imem_rsp_data = 32'h0000_0013;
                pend1 = imem1.imem_req_valid && imem1.imem_req_ready;
            end
        end
    end

    // Request monitor: every accepted fetch address is matched against the expected order.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && imem0.imem_req_valid && imem0.imem_req_ready) begin
                n_vectors++;
                if (exp_req.size() == 0) begin
                    n_miscompares++;
                    $display("[TB] FAIL req_addr: unexpected request at %h, expected none", imem0.imem_req_addr);
                end else begin
                    logic [63:0] e;
                    e = exp_req.pop_front();
                    if (imem0.imem_req_addr !== e) begin
                        n_miscompares++;
                        $display("[TB] FAIL req_addr: got %h, expected %h", imem0.imem_req_addr, e);
                    end
                end
            end
        end
    end

    // Decode-side monitor: every consumed instruction is matched against the expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && if_valid && if_ready) begin
                n_vectors++;
                if (exp_if.size() == 0) begin
                    n_miscompares++;
                    $display("[TB] FAIL if_out: unexpected instr %h pc %h, expected none", if_instr, if_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_if.pop_front();
                    if (if_instr !== e.instr || if_pc !== e.pc) begin
                        n_miscompares++;
                        $display("[TB] FAIL if_out: got instr %h pc %h, expected instr %h pc %h",
                                 if_instr, if_pc, e.instr, e.pc);
                    end
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [63:0] wrap_addr [2];
        logic [63:0] wrap_first_pc;
        int          n_wrap;
        bit          got_pc;

        rst = 1'b1;
        rst1 = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        redirect_valid1 = 1'b0;
        redirect_pc1 = '0;
        if_ready1 = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2;

        $display("[TB] reset values");
        checkOutput("rst_req_valid", {63'b0, imem0.imem_req_valid}, 64'h0);
        checkOutput("rst_req_addr", imem0.imem_req_addr, 64'h0);
        checkOutput("rst_if_valid", {63'b0, if_valid}, 64'h0);
        checkOutput("rst_if_instr", {32'b0, if_instr}, 64'h0);
        checkOutput("rst_if_pc", if_pc, 64'h0);
        checkOutput("rst_wrap_addr", imem1.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        $display("[TB] PC wrap from RESET_PC=FFFF_FFFF_FFFF_FFFC");
        wrap_addr[0] = 64'h1;
        wrap_addr[1] = 64'h1;
        wrap_first_pc = 64'h1;
        n_wrap = 0;
        got_pc = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (imem1.imem_req_valid && imem1.imem_req_ready && n_wrap < 2) begin
                wrap_addr[n_wrap] = imem1.imem_req_addr;
                n_wrap++;
            end
            if (if_valid1 && !got_pc) begin
                wrap_first_pc = if_pc1;
                got_pc = 1'b1;
            end
        end
        rst1 = 1'b1;
        checkOutput("wrap_first_fetch", wrap_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap_second_fetch", wrap_addr[1], 64'h0);
        checkOutput("wrap_first_if_pc", wrap_first_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        $display("[TB] streaming with ready memory and decode");
        mem_mode = 0;
        applyStimulus(1'b1, 1'b1);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h8);
        expect_entry(32'h0000_0013, 64'h0);
        expect_entry(32'h0000_0013, 64'h4);
        expect_entry(32'h0000_0013, 64'h8);
        @(negedge clk);
        rst = 1'b0;
        wait_fire(64'h8);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        wait_drain();

        $display("[TB] decode stalled, FIFO fills");
        pulse_reset();
        mem_mode = 1;
        applyStimulus(1'b1, 1'b0);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        rst = 1'b0;
        wait_fire(64'h4);
        repeat (8) @(negedge clk);
        #2;
        checkOutput("full_req_valid", {63'b0, imem0.imem_req_valid}, 64'h0);
        checkOutput("full_if_valid", {63'b0, if_valid}, 64'h1);
        checkOutput("full_head_pc", if_pc, 64'h0);
        exp_req.push_back(64'h8);
        expect_entry(32'h0000_0003, 64'h0);
        expect_entry(32'h0000_0007, 64'h4);
        expect_entry(32'h0000_000B, 64'h8);
        applyStimulus(1'b1, 1'b1);
        wait_fire(64'h8);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        wait_drain();

        $display("[TB] redirect while waiting on PC 0x8");
        pulse_reset();
        applyStimulus(1'b1, 1'b1);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h8);
        exp_req.push_back(64'h1000);
        expect_entry(32'h0000_0003, 64'h0);
        expect_entry(32'h0000_0007, 64'h4);
        expect_entry(32'h0000_1003, 64'h1000);
        rst = 1'b0;
        wait_fire(64'h8);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 64'h1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        checkOutput("redir_wait_if_valid", {63'b0, if_valid}, 64'h0);
        checkOutput("redir_wait_req_addr", imem0.imem_req_addr, 64'h1000);
        wait_fire(64'h1000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        wait_drain();

        $display("[TB] redirect on request handshake at 0x4");
        pulse_reset();
        applyStimulus(1'b1, 1'b1);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h200);
        expect_entry(32'h0000_0003, 64'h0);
        expect_entry(32'h0000_0203, 64'h200);
        rst = 1'b0;
        wait_fire(64'h4);
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_fire(64'h200);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        wait_drain();

        $display("[TB] reset while waiting with buffered data");
        pulse_reset();
        applyStimulus(1'b1, 1'b0);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        rst = 1'b0;
        wait_fire(64'h4);
        checkOutput("pre_rst_if_valid", {63'b0, if_valid}, 64'h1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("mid_rst_req_valid", {63'b0, imem0.imem_req_valid}, 64'h0);
        checkOutput("mid_rst_req_addr", imem0.imem_req_addr, 64'h0);
        checkOutput("mid_rst_if_valid", {63'b0, if_valid}, 64'h0);
        checkOutput("mid_rst_if_instr", {32'b0, if_instr}, 64'h0);
        checkOutput("mid_rst_if_pc", if_pc, 64'h0);
        repeat (2) @(negedge clk);
        exp_req.push_back(64'h0);
        expect_entry(32'h0000_0003, 64'h0);
        rst = 1'b0;
        wait_fire(64'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
